// File: rtl/keypad_scan.sv
// 4-row x 5-column matrix keypad scanner with 2-FF row synchronizer, tick-based debounce,
// and a one-cycle key-valid pulse. Optional auto-repeat is enabled with `define KEY_REPEAT_EN.
module keypad_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_TICKS = 10,
  parameter int REP_DELAY = 500,
  parameter int REP_RATE  = 100
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [3:0] i_row,
  output logic [4:0] o_col,
  output logic       o_key_valid,
  output logic [4:0] o_key_value,
  output logic       o_key_held
);

  localparam int                DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam int                DEB_W    = $clog2(DEB_TICKS + 1);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_TICKS);
  localparam logic [DEB_W-1:0]  DEB_ONE  = DEB_W'(1);

  if (SCAN_DIV < 2 || DEB_TICKS < 1 || REP_DELAY < 1 || REP_RATE < 1) begin : g_param_check
    $error("keypad_scan: SCAN_DIV must be >= 2; DEB_TICKS, REP_DELAY, REP_RATE must be >= 1");
  end

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       row_meta, row_sync;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [2:0]       col_idx, col_nxt;
  logic [1:0]       cap_row, cap_row_nxt;
  logic [2:0]       cap_col, cap_col_nxt;
  logic [DEB_W-1:0] deb_cnt, deb_nxt;
  logic [DEB_W-1:0] rel_cnt, rel_nxt;
  logic [4:0]       value_nxt;
  logic             valid_nxt, held_nxt;
  logic [1:0]       first_low;
  logic             any_low, cap_low;
  logic [4:0]       key_code;

`ifdef KEY_REPEAT_EN
  localparam int               REP_MAXV  = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int               REP_W     = $clog2(REP_MAXV + 1);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REP_DELAY);
  localparam logic [REP_W-1:0] REP_STEP  = REP_W'(REP_RATE);

  logic [REP_W-1:0] rep_cnt, rep_cnt_nxt, rep_inc;
  logic             rep_armed, rep_armed_nxt;

  assign rep_inc = rep_cnt + REP_W'(1);
`endif

  function automatic logic [2:0] advance(input logic [2:0] c);
    return (c == 3'd4) ? 3'd0 : c + 3'd1;
  endfunction

  assign tick     = (div_cnt == DIV_LAST);
  assign any_low  = ~&row_sync;
  assign cap_low  = ~row_sync[cap_row];
  assign key_code = ({3'b000, cap_row} * 5'd5) + {2'b00, cap_col};
  assign o_col    = ~(5'b00001 << col_idx);

  // Lowest row index wins when several rows are low in the driven column.
  always_comb begin
    first_low = 2'd3;
    if (!row_sync[0])      first_low = 2'd0;
    else if (!row_sync[1]) first_low = 2'd1;
    else if (!row_sync[2]) first_low = 2'd2;
  end

  // o_key_valid is a bare one-cycle strobe: there is no ready, the consumer must take
  // o_key_value in the same cycle; o_key_value stays stable until the next strobe.
  always_comb begin
    state_nxt   = state;
    col_nxt     = col_idx;
    cap_row_nxt = cap_row;
    cap_col_nxt = cap_col;
    deb_nxt     = deb_cnt;
    rel_nxt     = rel_cnt;
    value_nxt   = o_key_value;
    valid_nxt   = 1'b0;
    held_nxt    = o_key_held;
`ifdef KEY_REPEAT_EN
    rep_cnt_nxt   = rep_cnt;
    rep_armed_nxt = rep_armed;
`endif
    if (tick) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            cap_row_nxt = first_low;
            cap_col_nxt = col_idx;
            deb_nxt     = DEB_ONE;
            state_nxt   = DEBOUNCE;
          end else begin
            col_nxt = advance(col_idx);
          end
        end
        DEBOUNCE: begin
          if (!cap_low) begin
            deb_nxt   = '0;
            state_nxt = SCAN;
            col_nxt   = advance(col_idx);
          end else if (deb_cnt >= DEB_MAX) begin
            // The capture tick counts as 1, so acceptance lands DEB_TICKS ticks after it.
            value_nxt = key_code;
            valid_nxt = 1'b1;
            held_nxt  = 1'b1;
            deb_nxt   = '0;
            rel_nxt   = '0;
            state_nxt = HELD;
`ifdef KEY_REPEAT_EN
            rep_cnt_nxt   = '0;
            rep_armed_nxt = 1'b0;
`endif
          end else begin
            deb_nxt = deb_cnt + DEB_ONE;
          end
        end
        HELD: begin
          if (cap_low) begin
            rel_nxt = '0;
`ifdef KEY_REPEAT_EN
            if ((!rep_armed && rep_inc == REP_FIRST) || (rep_armed && rep_inc == REP_STEP)) begin
              valid_nxt     = 1'b1;
              rep_cnt_nxt   = '0;
              rep_armed_nxt = 1'b1;
            end else begin
              rep_cnt_nxt = rep_inc;
            end
`endif
          end else begin
`ifdef KEY_REPEAT_EN
            rep_cnt_nxt   = '0;
            rep_armed_nxt = 1'b0;
`endif
            if ((rel_cnt + DEB_ONE) >= DEB_MAX) begin
              rel_nxt   = '0;
              held_nxt  = 1'b0;
              state_nxt = SCAN;
              col_nxt   = advance(col_idx);
            end else begin
              rel_nxt = rel_cnt + DEB_ONE;
            end
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      row_meta    <= 4'hF;
      row_sync    <= 4'hF;
      div_cnt     <= '0;
      state       <= SCAN;
      col_idx     <= 3'd0;
      cap_row     <= 2'd0;
      cap_col     <= 3'd0;
      deb_cnt     <= '0;
      rel_cnt     <= '0;
      o_key_valid <= 1'b0;
      o_key_value <= 5'd31;
      o_key_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt     <= '0;
      rep_armed   <= 1'b0;
`endif
    end else begin
      row_meta    <= i_row;
      row_sync    <= row_meta;
      div_cnt     <= tick ? '0 : div_cnt + DIV_W'(1);
      state       <= state_nxt;
      col_idx     <= col_nxt;
      cap_row     <= cap_row_nxt;
      cap_col     <= cap_col_nxt;
      deb_cnt     <= deb_nxt;
      rel_cnt     <= rel_nxt;
      o_key_valid <= valid_nxt;
      o_key_value <= value_nxt;
      o_key_held  <= held_nxt;
`ifdef KEY_REPEAT_EN
      rep_cnt     <= rep_cnt_nxt;
      rep_armed   <= rep_armed_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad plant drives i_row from pressed keys and o_col, and a
// tick-level timestamp model predicts column, pulses, key value and held flag.
module tb_keypad_scan;

  localparam int SCAN_DIV  = 4;
  localparam int DEB       = 3;
  localparam int REP_DELAY = 5;
  localparam int REP_RATE  = 2;
  localparam int M_IDLE = 0, M_CAND = 1, M_HELD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  row;
  logic [4:0]  col, key_value;
  logic        key_valid, key_held;
  logic [19:0] pressed = '0;

  int total = 0, bad = 0, pulses = 0;

  int         m_col, m_mode, m_row, m_capcol, m_t, m_cap_t, m_last_low_t, m_last_high_t;
  logic       exp_pulse, exp_held;
  logic [4:0] exp_value;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  keypad_scan #(
    .SCAN_DIV (SCAN_DIV),
    .DEB_TICKS(DEB),
    .REP_DELAY(REP_DELAY),
    .REP_RATE (REP_RATE)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rst_n),
    .i_row      (row),
    .o_col      (col),
    .o_key_valid(key_valid),
    .o_key_value(key_value),
    .o_key_held (key_held)
  );

  // Keypad plant: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        if (pressed[r*5+c] && !col[c]) row[r] = 1'b0;
  end

  function automatic logic [4:0] col_pattern(input int c);
    logic [4:0] one;
    one = 5'b00001;
    return ~(one << c);
  endfunction

  function automatic logic [3:0] plant_rows(input int c);
    logic [3:0] rows;
    for (int r = 0; r < 4; r++) rows[r] = ~pressed[r*5+c];
    return rows;
  endfunction

  task automatic model_reset();
    m_col = 0; m_mode = M_IDLE; m_row = 0; m_capcol = 0; m_t = 0;
    m_cap_t = 0; m_last_low_t = 0; m_last_high_t = 0;
    exp_pulse = 1'b0; exp_held = 1'b0; exp_value = 5'd31;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [3:0] rows);
    exp_pulse = 1'b0;
    m_t++;
    if (m_mode == M_IDLE) begin
      if (rows != 4'hF) begin
        for (int r = 3; r >= 0; r--) if (!rows[r]) m_row = r;
        m_capcol = m_col; m_cap_t = m_t; m_mode = M_CAND;
      end else m_col = (m_col + 1) % 5;
    end else if (m_mode == M_CAND) begin
      if (rows[m_row]) begin
        m_mode = M_IDLE; m_col = (m_col + 1) % 5;
      end else if (m_t - m_cap_t == DEB) begin
        exp_pulse = 1'b1; exp_held = 1'b1;
        exp_value = 5'(m_row * 5 + m_capcol);
        exp_q.push_back(exp_value);
        m_mode = M_HELD; m_last_low_t = m_t; m_last_high_t = m_t;
      end
    end else begin
      if (!rows[m_row]) begin
        m_last_low_t = m_t;
`ifdef KEY_REPEAT_EN
        if (m_t - m_last_high_t >= REP_DELAY && (m_t - m_last_high_t - REP_DELAY) % REP_RATE == 0) begin
          exp_pulse = 1'b1;
          exp_q.push_back(exp_value);
        end
`endif
      end else begin
        m_last_high_t = m_t;
        if (m_t - m_last_low_t >= DEB) begin
          exp_held = 1'b0; m_mode = M_IDLE; m_col = (m_col + 1) % 5;
        end
      end
    end
  endtask

  // Each step covers one full prescaler period; called right after a tick (or reset release).
  task automatic run_ticks(input int n);
    logic [3:0] s;
    logic [4:0] old_col, v;
    for (int k = 0; k < n; k++) begin
      old_col = col_pattern(m_col);
      s = plant_rows(m_col);
      model_step(s);
      for (int i = 0; i < SCAN_DIV; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (key_valid === 1'b1) pulses++;
        total++;
        if (i < SCAN_DIV - 1) begin
          if (key_valid !== 1'b0 || col !== old_col) begin
            bad++;
            $display("FAIL between_ticks t=%0d: valid=%b col=%b, expected valid=0 col=%b", m_t, key_valid, col, old_col);
          end
        end else begin
          if (key_valid !== exp_pulse || key_held !== exp_held || key_value !== exp_value || col !== col_pattern(m_col)) begin
            bad++;
            $display("FAIL tick_state t=%0d: valid=%b held=%b value=%0d col=%b, expected valid=%b held=%b value=%0d col=%b",
                     m_t, key_valid, key_held, key_value, col, exp_pulse, exp_held, exp_value, col_pattern(m_col));
          end
          if (exp_pulse) begin
            v = exp_q.pop_front();
            total++;
            if (key_valid !== 1'b1 || key_value !== v) begin
              bad++;
              $display("FAIL pulse_value t=%0d: valid=%b value=%0d, expected valid=1 value=%0d", m_t, key_valid, key_value, v);
            end
          end
        end
      end
    end
  endtask

  task automatic wait_mode(input int mode, input string name);
    int n;
    n = 0;
    while (m_mode != mode && n < 25) begin
      run_ticks(1);
      n++;
    end
    total++;
    if (m_mode != mode) begin
      bad++;
      $display("FAIL wait_%s: state not reached within 25 ticks (mode=%0d, expected %0d)", name, m_mode, mode);
    end
  endtask

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_col", {3'b0, col}, 8'h1E);
    check_val("reset_valid", {7'b0, key_valid}, 8'd0);
    check_val("reset_value", {3'b0, key_value}, 8'd31);
    check_val("reset_held", {7'b0, key_held}, 8'd0);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    logic [4:0] seq [6];
    seq = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111, 5'b11110};
    pulses = 0;
    for (int k = 1; k < 6; k++) begin
      run_ticks(1);
      check_val("idle_col_seq", {3'b0, col}, {3'b0, seq[k]});
    end
    run_ticks(7);
    check_val("idle_no_pulse", 8'(pulses), 8'd0);
    check_val("idle_value", {3'b0, key_value}, 8'd31);
  endtask

  task automatic test_clean_press();
    pulses = 0;
    pressed = '0; pressed[2*5+3] = 1'b1;
    wait_mode(M_HELD, "clean_accept");
    run_ticks(20);
    check_val("clean_pulses", 8'(pulses), 8'd1);
    check_val("clean_value", {3'b0, key_value}, 8'd13);
    check_val("clean_held", {7'b0, key_held}, 8'd1);
    check_val("clean_col_frozen", {3'b0, col}, 8'h17);
    pressed = '0;
    run_ticks(2);
    check_val("clean_held_during_release", {7'b0, key_held}, 8'd1);
    check_val("clean_col_during_release", {3'b0, col}, 8'h17);
    run_ticks(1);
    check_val("clean_released", {7'b0, key_held}, 8'd0);
    check_val("clean_col_advanced", {3'b0, col}, 8'h0F);
  endtask

  task automatic test_bounce();
    pulses = 0;
    pressed = '0; pressed[1*5+2] = 1'b1;
    wait_mode(M_CAND, "bounce_capture");
    run_ticks(1);
    pressed = '0;
    run_ticks(1);
    check_val("bounce_glitch_no_pulse", 8'(pulses), 8'd0);
    check_val("bounce_glitch_not_held", {7'b0, key_held}, 8'd0);
    pressed[1*5+2] = 1'b1;
    wait_mode(M_HELD, "bounce_accept");
    check_val("bounce_pulses", 8'(pulses), 8'd1);
    check_val("bounce_value", {3'b0, key_value}, 8'd7);
    pressed = '0;
    run_ticks(DEB + 2);
  endtask

  task automatic test_multi_row();
    pulses = 0;
    pressed = '0; pressed[0] = 1'b1; pressed[3*5+0] = 1'b1;
    wait_mode(M_HELD, "multi_accept");
    check_val("multi_value", {3'b0, key_value}, 8'd0);
    check_val("multi_pulses", 8'(pulses), 8'd1);
    pressed = '0;
    run_ticks(1);
    pressed[0] = 1'b1; pressed[3*5+0] = 1'b1;
    run_ticks(1);
    pressed = '0;
    run_ticks(2);
    check_val("multi_held_after_bounce", {7'b0, key_held}, 8'd1);
    run_ticks(1);
    check_val("multi_released", {7'b0, key_held}, 8'd0);
    run_ticks(2);
  endtask

  task automatic test_second_key();
    pulses = 0;
    pressed = '0; pressed[0*5+4] = 1'b1;
    wait_mode(M_HELD, "second_first_accept");
    pressed[2*5+4] = 1'b1; pressed[1*5+1] = 1'b1;
    run_ticks(6);
    check_val("second_ignored_pulses", 8'(pulses), 8'd1);
    check_val("second_ignored_value", {3'b0, key_value}, 8'd4);
    pressed[0*5+4] = 1'b0;
    run_ticks(12);
    check_val("second_after_release_pulses", 8'(pulses), 8'd2);
    check_val("second_after_release_value", {3'b0, key_value}, 8'd6);
    pressed = '0;
    run_ticks(DEB + 2);
  endtask

  task automatic test_reset_mid();
    pressed = '0; pressed[3*5+1] = 1'b1;
    wait_mode(M_CAND, "rstmid_capture");
    run_ticks(1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rstmid_col", {3'b0, col}, 8'h1E);
    check_val("rstmid_valid", {7'b0, key_valid}, 8'd0);
    check_val("rstmid_value", {3'b0, key_value}, 8'd31);
    check_val("rstmid_held", {7'b0, key_held}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    pulses = 0;
    wait_mode(M_HELD, "rstmid_reaccept");
    check_val("rstmid_pulses", 8'(pulses), 8'd1);
    check_val("rstmid_value_after", {3'b0, key_value}, 8'd16);
    pressed = '0;
    run_ticks(DEB + 2);
  endtask

  task automatic test_hold_repeat();
    int exp_n;
`ifdef KEY_REPEAT_EN
    exp_n = 5;
`else
    exp_n = 1;
`endif
    pulses = 0;
    pressed = '0; pressed[2*5+4] = 1'b1;
    wait_mode(M_HELD, "repeat_accept");
    run_ticks(12);
    check_val("repeat_pulses_held", 8'(pulses), 8'(exp_n));
    check_val("repeat_value", {3'b0, key_value}, 8'd14);
    pressed = '0;
    run_ticks(6);
    check_val("repeat_pulses_after_release", 8'(pulses), 8'(exp_n));
  endtask

  task automatic test_random();
    int k;
    for (int it = 0; it < 20; it++) begin
      pressed = '0;
      k = $urandom_range(0, 19);
      pressed[k] = 1'b1;
      run_ticks($urandom_range(1, 9));
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 19);
        pressed[k] = 1'b1;
        run_ticks($urandom_range(1, 4));
      end
      pressed = '0;
      run_ticks($urandom_range(1, 6));
    end
    pressed = '0;
    run_ticks(DEB + 6);
    check_val("random_final_held", {7'b0, key_held}, 8'd0);
  endtask

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_idle_scan();
    test_clean_press();
    test_bounce();
    test_multi_row();
    test_second_key();
    test_reset_mid();
    test_hold_repeat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
